// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, legal-window check and IF/ID register with delay-slot redirect.
// One-cycle IF->ID latency; stall freezes PC and IF/ID (redirect is ignored while stalled).
module if_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] f_pc_o,
  output logic [31:0] d_instr_o,
  output logic [31:0] d_pc_o,
  output logic [31:0] d_pc8_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);

  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q;
  logic [31:0] d_pc8_q;
  logic        fault_q;
  logic [31:0] fault_pc_q;
  logic        fetch_legal;

  assign fetch_legal = (f_pc_q >= PC_RESET) && (f_pc_q <= PC_LAST);

  // Redirect does not flush IF/ID: the word fetched this cycle is the delay slot.
  always_comb begin
    f_pc_d    = redirect_i ? {redirect_pc_i[31:2], 2'b00} : f_pc_q + 32'd4;
    d_instr_d = fetch_legal ? imem_data_i : NOP;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      f_pc_q     <= PC_RESET;
      d_instr_q  <= NOP;
      d_pc_q     <= PC_RESET;
      d_pc8_q    <= PC_RESET + 32'd8;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0000_0000;
    end else if (!stall_i) begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= f_pc_q;
      d_pc8_q   <= f_pc_q + 32'd8;
      // Only the first out-of-window fetch is recorded.
      if (!fetch_legal && !fault_q) begin
        fault_q    <= 1'b1;
        fault_pc_q <= f_pc_q;
      end
    end
  end

  assign imem_addr_o = f_pc_q;
  assign f_pc_o      = f_pc_q;
  assign d_instr_o   = d_instr_q;
  assign d_pc_o      = d_pc_q;
  assign d_pc8_o     = d_pc8_q;
  assign fault_o     = fault_q;
  assign fault_pc_o  = fault_pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed scenarios plus randomized run against a behavioural fetch model.
module tb_if_fetch;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_LAST  = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_data, f_pc, d_instr, d_pc, d_pc8, fault_pc;
  logic        fault;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_dpc, m_fpc;
  logic        m_fault;

  if_fetch dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .f_pc_o(f_pc), .d_instr_o(d_instr), .d_pc_o(d_pc), .d_pc8_o(d_pc8),
    .fault_o(fault), .fault_pc_o(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + ((a - PC_RESET) >> 2);
  endfunction

  assign imem_data = mem_word(imem_addr);

  function automatic bit in_window(input logic [31:0] pc);
    return (pc >= PC_RESET) && (pc <= PC_LAST);
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after.
  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    if (rst) begin
      m_pc = PC_RESET; m_instr = 0; m_dpc = PC_RESET; m_fault = 0; m_fpc = 0;
    end else if (!st) begin
      m_instr = in_window(m_pc) ? mem_word(m_pc) : 32'h0;
      m_dpc   = m_pc;
      if (!in_window(m_pc) && !m_fault) begin m_fault = 1; m_fpc = m_pc; end
      m_pc = rd ? (rpc & 32'hFFFF_FFFC) : m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0);
    tests++; if (f_pc !== 32'h3000) begin fails++; $display("FAIL reset_f_pc got %h want 3000", f_pc); end
    tests++; if (d_instr !== 32'h0) begin fails++; $display("FAIL reset_d_instr got %h want 0", d_instr); end
    tests++; if (d_pc !== 32'h3000) begin fails++; $display("FAIL reset_d_pc got %h want 3000", d_pc); end
    tests++; if (d_pc8 !== 32'h3008) begin fails++; $display("FAIL reset_d_pc8 got %h want 3008", d_pc8); end
    tests++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin fails++; $display("FAIL reset_fault got %b/%h want 0/0", fault, fault_pc); end
    reset = 0;
    #1;
    tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL first_imem_addr got %h want 3000", imem_addr); end
  endtask

  task automatic test_sequential;
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0);
      tests++; if (f_pc !== 32'h3000 + 4*i) begin fails++; $display("FAIL seq_f_pc[%0d] got %h want %h", i, f_pc, 32'h3000 + 4*i); end
      tests++; if (d_instr !== 32'h1000_0000 + i - 1) begin fails++; $display("FAIL seq_d_instr[%0d] got %h want %h", i, d_instr, 32'h1000_0000 + i - 1); end
      tests++; if (d_pc8 !== d_pc + 32'd8 || d_pc !== 32'h3000 + 4*(i-1)) begin fails++; $display("FAIL seq_d_pc[%0d] got %h/%h", i, d_pc, d_pc8); end
      tests++; if (imem_addr !== f_pc) begin fails++; $display("FAIL seq_imem_addr got %h want %h", imem_addr, f_pc); end
    end
  endtask

  task automatic test_redirect;
    step(0, 0, 0, 0);  // f_pc 300C -> 3010
    tests++; if (f_pc !== 32'h3010) begin fails++; $display("FAIL redir_setup got %h want 3010", f_pc); end
    step(0, 0, 1, 32'h0000_3103);
    tests++; if (d_pc !== 32'h3010 || d_instr !== 32'h1000_0004) begin fails++; $display("FAIL redir_delay_slot got %h/%h want 3010/10000004", d_pc, d_instr); end
    tests++; if (f_pc !== 32'h3100) begin fails++; $display("FAIL redir_target got %h want 3100", f_pc); end
    step(0, 0, 0, 0);
    tests++; if (d_pc !== 32'h3100 || d_instr !== 32'h1000_0040 || d_pc8 !== 32'h3108) begin fails++; $display("FAIL redir_after got %h/%h/%h", d_pc, d_instr, d_pc8); end
  endtask

  task automatic test_stall;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    tests++; if (f_pc !== 32'h3020) begin fails++; $display("FAIL stall_setup got %h want 3020", f_pc); end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 32'h0000_3200);
      tests++; if (f_pc !== 32'h3020 || d_pc !== 32'h301C || d_instr !== 32'h1000_0007 || d_pc8 !== 32'h3024) begin
        fails++; $display("FAIL stall_frozen[%0d] got %h/%h/%h/%h", i, f_pc, d_pc, d_instr, d_pc8); end
    end
    step(0, 0, 1, 32'h0000_3200);
    tests++; if (f_pc !== 32'h3200 || d_pc !== 32'h3020 || d_instr !== 32'h1000_0008) begin
      fails++; $display("FAIL stall_release got %h/%h/%h want 3200/3020/10000008", f_pc, d_pc, d_instr); end
  endtask

  task automatic test_fault;
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h0000_2FFC);
    step(0, 1, 0, 0);  // illegal fetch held by stall: no capture
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL fault_in_stall got %b want 0", fault); end
    step(0, 0, 1, 32'h0000_7000);
    tests++; if (d_instr !== 32'h0 || d_pc !== 32'h2FFC) begin fails++; $display("FAIL fault_nop got %h/%h want 0/2ffc", d_instr, d_pc); end
    tests++; if (fault !== 1'b1 || fault_pc !== 32'h2FFC) begin fails++; $display("FAIL fault_capture got %b/%h want 1/2ffc", fault, fault_pc); end
    step(0, 0, 0, 0);
    tests++; if (d_pc !== 32'h7000 || d_instr !== 32'h0 || fault_pc !== 32'h2FFC) begin fails++; $display("FAIL fault_sticky got %h/%h/%h", d_pc, d_instr, fault_pc); end
  endtask

  task automatic test_end_window;
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h0000_6FF0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    tests++; if (f_pc !== 32'h6FFC) begin fails++; $display("FAIL end_setup got %h want 6ffc", f_pc); end
    step(0, 0, 0, 0);
    tests++; if (d_instr !== 32'h1000_0FFF || fault !== 1'b0 || f_pc !== 32'h7000) begin fails++; $display("FAIL end_last_legal got %h/%b/%h", d_instr, fault, f_pc); end
    step(0, 0, 0, 0);
    tests++; if (d_instr !== 32'h0 || d_pc !== 32'h7000 || fault !== 1'b1 || fault_pc !== 32'h7000 || f_pc !== 32'h7004) begin
      fails++; $display("FAIL end_no_wrap got %h/%h/%b/%h/%h", d_instr, d_pc, fault, fault_pc, f_pc); end
  endtask

  task automatic test_reset_priority;
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL prio_setup fault got %b want 1", fault); end
    step(1, 1, 1, 32'h0000_4000);
    tests++; if (f_pc !== 32'h3000 || d_instr !== 32'h0 || d_pc !== 32'h3000 || d_pc8 !== 32'h3008 || fault !== 1'b0 || fault_pc !== 32'h0) begin
      fails++; $display("FAIL reset_priority got %h/%h/%h/%h/%b/%h", f_pc, d_instr, d_pc, d_pc8, fault, fault_pc); end
  endtask

  task automatic test_random;
    logic [31:0] rpc;
    step(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rpc = $urandom;
        1: rpc = PC_RESET - 32'd8 + $urandom_range(0, 24);
        2: rpc = PC_LAST - 32'd12 + $urandom_range(0, 24);
        default: rpc = PC_RESET + $urandom_range(0, 32'h3FFF);
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rpc);
      tests++;
      if (f_pc !== m_pc || imem_addr !== m_pc || d_instr !== m_instr || d_pc !== m_dpc ||
          d_pc8 !== m_dpc + 32'd8 || fault !== m_fault || fault_pc !== m_fpc) begin
        fails++;
        $display("FAIL rand[%0d] got pc=%h instr=%h dpc=%h dpc8=%h f=%b fpc=%h want pc=%h instr=%h dpc=%h f=%b fpc=%h",
                 i, f_pc, d_instr, d_pc, d_pc8, fault, fault_pc, m_pc, m_instr, m_dpc, m_fault, m_fpc);
      end
    end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_redirect;
    test_stall;
    test_fault;
    test_end_window;
    test_reset_priority;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter PC_RESET, 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter IM_WORDS, 4096, instruction memory depth in words; legal fetch window is PC_RESET .. PC_RESET+4*IM_WORDS-4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit stall; holds PC and IF/ID register.
REQ-006 redirect  input  1  branch/jump taken, resolved in ID.
REQ-007 redirect_pc  input  32  branch/jump target from ID.
REQ-008 imem_addr  output  32  byte address driven to instruction memory.
REQ-009 imem_data  input  32  instruction word returned combinationally by instruction memory for imem_addr.
REQ-010 f_pc  output  32  current fetch PC.
REQ-011 d_instr  output  32  IF/ID registered instruction.
REQ-012 d_pc  output  32  IF/ID registered PC of d_instr.
REQ-013 d_pc8  output  32  d_pc+8, link address for jal/jalr.
REQ-014 fault  output  1  sticky: a fetch outside the legal window occurred.
REQ-015 fault_pc  output  32  PC of the first faulting fetch.

Function
REQ-016 imem_addr SHALL equal f_pc combinationally; no address latency; instruction for f_pc valid same cycle.
REQ-017 Edge with stall=0: d_instr <= fetched word, d_pc <= f_pc, f_pc <= next PC; IF/ID latency exactly one cycle.
REQ-018 Next PC: redirect=1 -> {redirect_pc[31:2],2'b00}; else f_pc+4, modulo 2^32.
REQ-019 Branch delay slot: redirect SHALL NOT flush IF/ID; the word fetched in the redirect cycle enters IF/ID normally.
REQ-020 Edge with stall=1: f_pc, d_instr, d_pc, d_pc8 unchanged; redirect ignored (ID is held and re-presents it after stall drops).
REQ-021 Priority: reset > stall > redirect > sequential increment.
REQ-022 Fetch legal iff PC_RESET <= f_pc <= PC_RESET+4*IM_WORDS-4; f_pc[1:0] always 00 by construction.
REQ-023 Illegal fetch (stall=0): d_instr <= 32'h0000_0000 (nop) instead of imem_data; d_pc <= f_pc; f_pc still advances per REQ-018.
REQ-024 First illegal fetch sets fault and captures fault_pc; later illegal fetches leave fault_pc unchanged; only reset clears.
REQ-025 Illegal fetch during stall=1 SHALL NOT set fault (no capture edge).
REQ-026 d_pc8 SHALL be registered together with d_pc, always equal d_pc+8 modulo 2^32.
REQ-027 Sequential PC reaching end of window: next fetch is illegal and handled by REQ-023; no wrap to PC_RESET.

Reset
REQ-028 Reset edge: f_pc=PC_RESET, d_instr=0, d_pc=PC_RESET, d_pc8=PC_RESET+8, fault=0, fault_pc=0.
REQ-029 Reset asserted mid-stall or with redirect=1: reset wins; values per REQ-028.
REQ-030 First post-reset fetch presents imem_addr=PC_RESET in the cycle reset deasserts.

Verification
REQ-031 Reset, then 3 idle cycles with memory word i = 32'h1000_0000+i -> f_pc 3000,3004,3008,300C; d_instr lags one cycle: 1000_0000,1000_0001,1000_0002; d_pc8 = d_pc+8.
REQ-032 redirect=1, redirect_pc=32'h0000_3103 at f_pc=3010 -> d_pc=3010 next cycle (delay slot kept), then f_pc=3100.
REQ-033 stall=1 for 2 cycles with redirect=1 at f_pc=3020 -> f_pc, d_instr, d_pc frozen; after stall=0, redirect applied on first free edge.
REQ-034 redirect_pc=32'h0000_2FFC -> d_instr=0, d_pc=2FFC, fault=1, fault_pc=2FFC; second illegal fetch at 7000 leaves fault_pc=2FFC.
REQ-035 Sequential run to f_pc=6FFC -> legal fetch; next f_pc=7000 illegal, nop inserted, fault set, no wrap.
REQ-036 reset asserted while stall=1, redirect=1, fault=1 -> all outputs per REQ-028 on that edge.
